mem_req_arbiter: RTL and testbench

Two-requester arbiter sharing one simplified-memory channel (MemReq/MemResp, as presented to the DRAM interleaver input) between the PCIe-to-DRAM streaming FSM (requester 0) and the Hast IP memory port (requester 1). It grants requests round-robin, keeps a presented request stable until the memory side grants it, and records the issuer of every accepted read in an in-order tag queue. Read responses are steered back to the issuing requester.

---
 rtl/mem_req_arbiter_if.sv | 37 +++
 rtl/mem_req_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_if.sv
// Request/response bus between two requesters, the arbiter and the memory channel.
// The arbiter uses the slave modport; the requester/memory side uses master.
interface mem_req_arbiter_if;
    logic [1:0]             req_valid;
    logic [1:0]             req_is_write;
    logic [1:0][63:0]       req_addr;
    logic [1:0][511:0]      req_data;
    logic [1:0]             req_grant;

    logic [1:0]             resp_valid;
    logic [1:0][511:0]      resp_data;
    logic [1:0]             resp_grant;

    logic                   mem_req_valid;
    logic                   mem_req_is_write;
    logic [63:0]            mem_req_addr;
    logic [511:0]           mem_req_data;
    logic                   mem_req_grant;

    logic                   mem_resp_valid;
    logic [511:0]           mem_resp_data;
    logic                   mem_resp_grant;

    modport slave (
        input  req_valid, req_is_write, req_addr, req_data, resp_grant,
        input  mem_req_grant, mem_resp_valid, mem_resp_data,
        output req_grant, resp_valid, resp_data,
        output mem_req_valid, mem_req_is_write, mem_req_addr, mem_req_data, mem_resp_grant
    );

    modport master (
        output req_valid, req_is_write, req_addr, req_data, resp_grant,
        output mem_req_grant, mem_resp_valid, mem_resp_data,
        input  req_grant, resp_valid, resp_data,
        input  mem_req_valid, mem_req_is_write, mem_req_addr, mem_req_data, mem_resp_grant
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter for two requesters on one memory channel, with an in-order
// tag queue that steers read responses back to the requester that issued them.
//
//   state | meaning
//   ARB   | pick among eligible requesters, present selection combinationally
//   HOLD  | selected request was not granted; keep presenting req[owner] until grant
module mem_req_arbiter #(
    parameter int LOG_DEPTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mem_req_arbiter_if.slave       bus,
    output logic [LOG_DEPTH:0]     outstanding_out,
    output logic [1:0][31:0]       grant_cnt_out,
    output logic                   err_orphan_out
);
    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam logic [LOG_DEPTH:0]   CNT_ONE  = 1;
    localparam logic [LOG_DEPTH:0]   CNT_FULL = DEPTH[LOG_DEPTH:0];
    localparam logic [LOG_DEPTH-1:0] PTR_ONE  = 1;

    typedef enum logic {ARB, HOLD} state_t;

    state_t                 state_q, state_d;
    logic                   rr_q, rr_d;
    logic                   owner_q, owner_d;
    logic                   sel, sel_valid;

    logic [DEPTH-1:0]       tag_q;
    logic [LOG_DEPTH-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LOG_DEPTH:0]     count_q;

    logic                   full, empty, head;
    logic [1:0]             eligible;
    logic                   accept, push, pop, orphan;
    logic [1:0]             resp_valid;
    logic                   mem_resp_grant;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign head  = tag_q[rd_ptr_q];

    // A read is only eligible when a tag slot is free, so a held read always fits.
    assign eligible[0] = bus.req_valid[0] && (bus.req_is_write[0] || !full);
    assign eligible[1] = bus.req_valid[1] && (bus.req_is_write[1] || !full);

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        sel       = 1'b0;
        sel_valid = 1'b0;
        case (state_q)
            ARB: begin
                if (eligible[0] && eligible[1]) begin
                    sel       = ~rr_q;
                    sel_valid = 1'b1;
                end else if (eligible[0]) begin
                    sel       = 1'b0;
                    sel_valid = 1'b1;
                end else if (eligible[1]) begin
                    sel       = 1'b1;
                    sel_valid = 1'b1;
                end
                if (sel_valid) begin
                    if (bus.mem_req_grant) begin
                        rr_d = sel;
                    end else begin
                        owner_d = sel;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                sel       = owner_q;
                sel_valid = bus.req_valid[owner_q];
                if (sel_valid && bus.mem_req_grant) begin
                    rr_d    = owner_q;
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    assign bus.mem_req_valid    = sel_valid;
    assign bus.mem_req_is_write = bus.req_is_write[sel];
    assign bus.mem_req_addr     = bus.req_addr[sel];
    assign bus.mem_req_data     = bus.req_data[sel];

    assign accept        = sel_valid && bus.mem_req_grant;
    assign bus.req_grant = accept ? (2'b01 << sel) : 2'b00;
    assign push          = accept && !bus.req_is_write[sel] && !full;

    always_comb begin
        resp_valid     = 2'b00;
        mem_resp_grant = 1'b0;
        orphan         = 1'b0;
        if (bus.mem_resp_valid) begin
            if (empty) begin
                mem_resp_grant = 1'b1;
                orphan         = 1'b1;
            end else begin
                resp_valid[head] = 1'b1;
                mem_resp_grant   = bus.resp_grant[head];
            end
        end
    end

    assign pop                = bus.mem_resp_valid && !empty && bus.resp_grant[head];
    assign bus.resp_valid     = resp_valid;
    assign bus.resp_data      = {2{bus.mem_resp_data}};
    assign bus.mem_resp_grant = mem_resp_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB;
            rr_q     <= 1'b1;
            owner_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                tag_q[wr_ptr_q] <= sel;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_out  <= '0;
            err_orphan_out <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (bus.req_grant[i]) begin
                    grant_cnt_out[i] <= grant_cnt_out[i] + 32'd1;
                end
            end
            if (orphan) begin
                err_orphan_out <= 1'b1;
            end
        end
    end

    assign outstanding_out = count_q;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: inputs change at negedge, outputs sampled 1ns later.
module tb_mem_req_arbiter;
    localparam int LD = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [LD:0]       outstanding;
    logic [1:0][31:0]  grant_cnt;
    logic              err_orphan;
    int                n_tests = 0;
    int                n_fail = 0;

    mem_req_arbiter_if bus ();

    mem_req_arbiter #(.LOG_DEPTH(LD)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .outstanding_out (outstanding),
        .grant_cnt_out   (grant_cnt),
        .err_orphan_out  (err_orphan)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.req_valid      = '0;
        bus.req_is_write   = '0;
        bus.req_addr       = '0;
        bus.req_data       = '0;
        bus.resp_grant     = '0;
        bus.mem_req_grant  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
        n_tests++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err_orphan); end
        n_tests++; if (grant_cnt !== 64'd0) begin n_fail++; $display("FAIL reset_cnt got %h want 0", grant_cnt); end
        n_tests++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req_valid got %b want 0", bus.mem_req_valid); end
        n_tests++; if (bus.req_grant !== 2'b00) begin n_fail++; $display("FAIL reset_req_grant got %b want 00", bus.req_grant); end
        n_tests++; if (bus.resp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_resp_valid got %b want 00", bus.resp_valid); end
        n_tests++; if (bus.mem_resp_grant !== 1'b0) begin n_fail++; $display("FAIL reset_mem_resp_grant got %b want 0", bus.mem_resp_grant); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.req_valid     = 2'b01;
            bus.req_is_write  = 2'b01;
            bus.req_addr[0]   = 64'h100 + 64'(i);
            bus.mem_req_grant = 1'b1;
            #1;
            n_tests++; if (bus.req_grant !== 2'b01) begin n_fail++; $display("FAIL single_grant[%0d] got %b want 01", i, bus.req_grant); end
            n_tests++; if (bus.mem_req_addr !== 64'h100 + 64'(i)) begin n_fail++; $display("FAIL single_addr[%0d] got %h want %h", i, bus.mem_req_addr, 64'h100 + 64'(i)); end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_tests++; if (grant_cnt[0] !== 32'd4) begin n_fail++; $display("FAIL single_cnt0 got %0d want 4", grant_cnt[0]); end
        n_tests++; if (grant_cnt[1] !== 32'd0) begin n_fail++; $display("FAIL single_cnt1 got %0d want 0", grant_cnt[1]); end
        n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL single_outstanding got %0d want 0", outstanding); end
        n_tests++; if (bus.req_grant !== 2'b00) begin n_fail++; $display("FAIL single_idle_grant got %b want 00", bus.req_grant); end
    endtask

    task automatic test_contention();
        logic [1:0]  exp_g;
        logic [63:0] exp_a;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.req_valid     = 2'b11;
            bus.req_is_write  = 2'b11;
            bus.req_addr[0]   = 64'h200;
            bus.req_addr[1]   = 64'h300;
            bus.mem_req_grant = 1'b1;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (i % 2 == 0) ? 64'h200 : 64'h300;
            #1;
            n_tests++; if (bus.req_grant !== exp_g) begin n_fail++; $display("FAIL contention_grant[%0d] got %b want %b", i, bus.req_grant, exp_g); end
            n_tests++; if (bus.mem_req_addr !== exp_a) begin n_fail++; $display("FAIL contention_addr[%0d] got %h want %h", i, bus.mem_req_addr, exp_a); end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_tests++; if (grant_cnt !== {32'd2, 32'd2}) begin n_fail++; $display("FAIL contention_cnt got %h want 2/2", grant_cnt); end
    endtask

    task automatic test_hold();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.req_valid[1]    = 1'b1;
            bus.req_is_write[1] = 1'b0;
            bus.req_addr[1]     = 64'hB1;
            bus.req_data[1]     = 512'hB1D;
            bus.req_valid[0]    = (i != 0);
            bus.req_is_write[0] = 1'b1;
            bus.req_addr[0]     = 64'hA0;
            bus.mem_req_grant   = 1'b0;
            #1;
            n_tests++; if (bus.mem_req_addr !== 64'hB1 || bus.mem_req_data !== 512'hB1D || bus.mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL hold_stable[%0d] got addr %h valid %b want addr b1 valid 1", i, bus.mem_req_addr, bus.mem_req_valid); end
            n_tests++; if (bus.req_grant !== 2'b00) begin n_fail++; $display("FAIL hold_nogrant[%0d] got %b want 00", i, bus.req_grant); end
        end
        @(negedge clk);
        bus.mem_req_grant = 1'b1;
        #1;
        n_tests++; if (bus.req_grant !== 2'b10) begin n_fail++; $display("FAIL hold_release got %b want 10", bus.req_grant); end
        @(negedge clk);
        bus.req_valid = 2'b01;
        #1;
        n_tests++; if (bus.req_grant !== 2'b01 || bus.mem_req_addr !== 64'hA0) begin n_fail++; $display("FAIL hold_next got %b addr %h want 01 addr a0", bus.req_grant, bus.mem_req_addr); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_tests++; if (outstanding !== 3'd1) begin n_fail++; $display("FAIL hold_outstanding got %0d want 1", outstanding); end
        n_tests++; if (grant_cnt !== {32'd1, 32'd1}) begin n_fail++; $display("FAIL hold_cnt got %h want 1/1", grant_cnt); end
    endtask

    task automatic test_routing();
        logic [1:0] who [3];
        who[0] = 2'b01; who[1] = 2'b10; who[2] = 2'b01;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.req_valid     = who[i];
            bus.req_is_write  = 2'b00;
            bus.req_addr[0]   = 64'hA + 64'(i);
            bus.req_addr[1]   = 64'hB;
            bus.mem_req_grant = 1'b1;
            #1;
            n_tests++; if (bus.req_grant !== who[i]) begin n_fail++; $display("FAIL route_accept[%0d] got %b want %b", i, bus.req_grant, who[i]); end
        end
        @(negedge clk);
        idle_inputs();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 512'hD1;
        bus.resp_grant     = 2'b11;
        #1;
        n_tests++; if (outstanding !== 3'd3) begin n_fail++; $display("FAIL route_outstanding3 got %0d want 3", outstanding); end
        n_tests++; if (bus.resp_valid !== 2'b01 || bus.resp_data[0] !== 512'hD1) begin n_fail++; $display("FAIL route_d1 got valid %b want 01", bus.resp_valid); end
        n_tests++; if (bus.mem_resp_grant !== 1'b1) begin n_fail++; $display("FAIL route_d1_grant got %b want 1", bus.mem_resp_grant); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.mem_resp_data = 512'hD2;
            bus.resp_grant    = 2'b01;
            #1;
            n_tests++; if (bus.resp_valid !== 2'b10) begin n_fail++; $display("FAIL route_d2_stall_valid[%0d] got %b want 10", i, bus.resp_valid); end
            n_tests++; if (bus.mem_resp_grant !== 1'b0) begin n_fail++; $display("FAIL route_d2_stall_grant[%0d] got %b want 0", i, bus.mem_resp_grant); end
        end
        n_tests++; if (outstanding !== 3'd2) begin n_fail++; $display("FAIL route_outstanding2 got %0d want 2", outstanding); end
        @(negedge clk);
        bus.resp_grant = 2'b11;
        #1;
        n_tests++; if (bus.resp_valid !== 2'b10 || bus.resp_data[1] !== 512'hD2 || bus.mem_resp_grant !== 1'b1) begin n_fail++; $display("FAIL route_d2 got valid %b grant %b want 10 / 1", bus.resp_valid, bus.mem_resp_grant); end
        @(negedge clk);
        bus.mem_resp_data = 512'hD3;
        #1;
        n_tests++; if (bus.resp_valid !== 2'b01 || bus.resp_data[0] !== 512'hD3 || bus.mem_resp_grant !== 1'b1) begin n_fail++; $display("FAIL route_d3 got valid %b grant %b want 01 / 1", bus.resp_valid, bus.mem_resp_grant); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL route_drained got %0d want 0", outstanding); end
        n_tests++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL route_no_orphan got %b want 0", err_orphan); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.req_valid     = 2'b01;
            bus.req_is_write  = 2'b00;
            bus.req_addr[0]   = 64'hF0 + 64'(i);
            bus.mem_req_grant = 1'b1;
            #1;
            n_tests++; if (bus.req_grant !== 2'b01) begin n_fail++; $display("FAIL full_fill[%0d] got %b want 01", i, bus.req_grant); end
        end
        @(negedge clk);
        bus.req_valid    = 2'b11;
        bus.req_is_write = 2'b10;
        bus.req_addr[0]  = 64'hF5;
        bus.req_addr[1]  = 64'hE0;
        #1;
        n_tests++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL full_outstanding got %0d want 4", outstanding); end
        n_tests++; if (bus.req_grant !== 2'b10 || bus.mem_req_is_write !== 1'b1) begin n_fail++; $display("FAIL full_write_passes got %b wr %b want 10 wr 1", bus.req_grant, bus.mem_req_is_write); end
        @(negedge clk);
        bus.req_valid = 2'b01;
        #1;
        n_tests++; if (bus.mem_req_valid !== 1'b0 || bus.req_grant !== 2'b00) begin n_fail++; $display("FAIL full_read_blocked got valid %b grant %b want 0 / 00", bus.mem_req_valid, bus.req_grant); end
        @(negedge clk);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 512'hCAFE;
        bus.resp_grant     = 2'b11;
        #1;
        n_tests++; if (bus.mem_resp_grant !== 1'b1 || bus.resp_valid !== 2'b01) begin n_fail++; $display("FAIL full_pop got grant %b valid %b want 1 / 01", bus.mem_resp_grant, bus.resp_valid); end
        n_tests++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL full_still_blocked got %b want 0", bus.mem_req_valid); end
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        #1;
        n_tests++; if (outstanding !== 3'd3) begin n_fail++; $display("FAIL full_after_pop got %0d want 3", outstanding); end
        n_tests++; if (bus.req_grant !== 2'b01 || bus.mem_req_addr !== 64'hF5) begin n_fail++; $display("FAIL full_read_granted got %b addr %h want 01 addr f5", bus.req_grant, bus.mem_req_addr); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_tests++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL full_refill got %0d want 4", outstanding); end
        n_tests++; if (grant_cnt !== {32'd1, 32'd5}) begin n_fail++; $display("FAIL full_cnt got %h want 1/5", grant_cnt); end
    endtask

    task automatic test_orphan_reset();
        do_reset();
        @(negedge clk);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 512'hBAD;
        #1;
        n_tests++; if (bus.mem_resp_grant !== 1'b1) begin n_fail++; $display("FAIL orphan_drain got %b want 1", bus.mem_resp_grant); end
        n_tests++; if (bus.resp_valid !== 2'b00) begin n_fail++; $display("FAIL orphan_no_route got %b want 00", bus.resp_valid); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            n_tests++; if (err_orphan !== 1'b1) begin n_fail++; $display("FAIL orphan_sticky[%0d] got %b want 1", i, err_orphan); end
        end
        @(negedge clk);
        bus.req_valid     = 2'b01;
        bus.req_addr[0]   = 64'hA0;
        bus.mem_req_grant = 1'b1;
        #1;
        n_tests++; if (bus.req_grant !== 2'b01) begin n_fail++; $display("FAIL orphan_pre_read got %b want 01", bus.req_grant); end
        @(negedge clk);
        bus.req_valid     = 2'b10;
        bus.req_addr[1]   = 64'hB7;
        bus.mem_req_grant = 1'b0;
        @(negedge clk);
        bus.req_valid    = 2'b11;
        bus.req_is_write = 2'b01;
        #1;
        n_tests++; if (bus.mem_req_addr !== 64'hB7) begin n_fail++; $display("FAIL rst_in_hold got %h want b7", bus.mem_req_addr); end
        n_tests++; if (outstanding !== 3'd1) begin n_fail++; $display("FAIL rst_pre_outstanding got %0d want 1", outstanding); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL rst_async_outstanding got %0d want 0", outstanding); end
        n_tests++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL rst_async_err got %b want 0", err_orphan); end
        n_tests++; if (bus.mem_req_addr !== 64'hA0 || bus.req_grant !== 2'b00) begin n_fail++; $display("FAIL rst_back_to_arb got %h grant %b want a0 / 00", bus.mem_req_addr, bus.req_grant); end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        bus.mem_resp_valid = 1'b1;
        #1;
        n_tests++; if (bus.mem_resp_grant !== 1'b1 || bus.resp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_late_resp_orphan got grant %b valid %b want 1 / 00", bus.mem_resp_grant, bus.resp_valid); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_tests++; if (err_orphan !== 1'b1) begin n_fail++; $display("FAIL rst_late_err got %b want 1", err_orphan); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_hold();
        test_routing();
        test_full();
        test_orphan_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
